// File: rtl/aligned_feature_loader.sv
// ============================================================================
//  Module      : aligned_feature_loader
//  Description : 2-D activation buffer; packed writes into the input column,
//                per-cell horizontal/vertical shifts, column 0 drives output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aligned_feature_loader #(
    parameter int unsigned aflDimY      = 128,
    parameter int unsigned aflDimX      = 6,
    parameter int unsigned inputWidth   = 32,
    parameter int unsigned elementWidth = 4,
    parameter int unsigned addrWidth    = 32
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic [inputWidth-1:0]             data_i,
    input  logic                              valid_i,
    input  logic [addrWidth-1:0]              input_addr_offset,
    output logic [aflDimY*elementWidth-1:0]   data_o,
    input  logic [aflDimX*aflDimY*2-1:0]      ctrl_load_direction_i
);

    localparam int unsigned c_in_elems = inputWidth / elementWidth;

    logic [elementWidth-1:0] cell_q [aflDimX][aflDimY];
    logic [elementWidth-1:0] cell_d [aflDimX][aflDimY];

    genvar gx, gy;
    generate
        for (gx = 0; gx < aflDimX; gx++) begin : g_col
            for (gy = 0; gy < aflDimY; gy++) begin : g_row
                logic [1:0]              w_ctrl;
                logic [elementWidth-1:0] w_right;
                logic [elementWidth-1:0] w_up;
                logic [elementWidth-1:0] w_down;
                logic [elementWidth-1:0] w_shift;
                logic                    w_wr;

                assign w_ctrl = ctrl_load_direction_i[(gx*aflDimY+gy)*2 +: 2];

                if (gx == aflDimX-1) begin : g_right_edge
                    assign w_right = '0;
                end else begin : g_right_cell
                    assign w_right = cell_q[gx+1][gy];
                end

                if (gy == aflDimY-1) begin : g_up_edge
                    assign w_up = '0;
                end else begin : g_up_cell
                    assign w_up = cell_q[gx][gy+1];
                end

                if (gy == 0) begin : g_down_edge
                    assign w_down = '0;
                end else begin : g_down_cell
                    assign w_down = cell_q[gx][gy-1];
                end

                // Full-width group compare: out-of-range offsets never alias a row group.
                if (gx == aflDimX-1) begin : g_wr_col
                    assign w_wr = valid_i &&
                                  (input_addr_offset == addrWidth'(gy / c_in_elems));
                end else begin : g_no_wr
                    assign w_wr = 1'b0;
                end

                assign w_shift = (w_ctrl == 2'b01) ? w_right :
                                 (w_ctrl == 2'b10) ? w_up    :
                                 (w_ctrl == 2'b11) ? w_down  :
                                                     cell_q[gx][gy];

                assign cell_d[gx][gy] = w_wr
                    ? data_i[(gy % c_in_elems)*elementWidth +: elementWidth]
                    : w_shift;
            end
        end

        for (gy = 0; gy < aflDimY; gy++) begin : g_out
            assign data_o[gy*elementWidth +: elementWidth] = cell_q[0][gy];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (nrst) begin
            for (int x = 0; x < int'(aflDimX); x++) begin
                for (int y = 0; y < int'(aflDimY); y++) begin
                    cell_q[x][y] <= '0;
                end
            end
        end else begin
            cell_q <= cell_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aligned_feature_loader.sv
// ============================================================================
//  Module      : tb_aligned_feature_loader
//  Description : Directed self-checking bench for aligned_feature_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aligned_feature_loader;

    localparam int DY = 128;
    localparam int DX = 6;
    localparam int IW = 32;
    localparam int EW = 4;
    localparam int AW = 32;
    localparam int DW = DY * EW;
    localparam int CW = DX * DY * 2;

    localparam int K_ZERO  = 0;
    localparam int K_GRP   = 1;
    localparam int K_MOD16 = 2;
    localparam int K_UP    = 3;
    localparam int K_DOWN  = 4;
    localparam int K_OFF3  = 5;
    localparam int K_ONES8 = 6;

    logic          clk;
    logic          nrst;
    logic [IW-1:0] data_i;
    logic          valid_i;
    logic [AW-1:0] input_addr_offset;
    logic [DW-1:0] data_o;
    logic [CW-1:0] ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    aligned_feature_loader #(
        .aflDimY(DY), .aflDimX(DX), .inputWidth(IW),
        .elementWidth(EW), .addrWidth(AW)
    ) dut (
        .clk                  (clk),
        .nrst                 (nrst),
        .data_i               (data_i),
        .valid_i              (valid_i),
        .input_addr_offset    (input_addr_offset),
        .data_o               (data_o),
        .ctrl_load_direction_i(ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(int kind);
        logic [DW-1:0] v;
        logic [EW-1:0] e;
        v = '0;
        for (int y = 0; y < DY; y++) begin
            case (kind)
                K_GRP:   e = EW'(y / 8);
                K_MOD16: e = EW'(y % 16);
                K_UP:    e = (y == DY-1) ? '0 : EW'((y + 1) % 16);
                K_DOWN:  e = (y == 0) ? '0 : EW'((y - 1) % 16);
                K_OFF3:  e = (y >= 24 && y < 32) ? EW'(y - 24) : '0;
                K_ONES8: e = (y < 8) ? EW'(1) : '0;
                default: e = '0;
            endcase
            v[y*EW +: EW] = e;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(logic [1:0] code);
        ctrl = {(DX*DY){code}};
    endtask

    task automatic chk(string tag, logic [DW-1:0] exp);
        n_cmp++;
        assert (data_o === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, data_o, exp);
        end
    endtask

    task automatic wr(logic [AW-1:0] g, logic [IW-1:0] d);
        valid_i           = 1'b1;
        input_addr_offset = g;
        data_i            = d;
        tick();
        valid_i           = 1'b0;
    endtask

    // Column 5 group g gets element value g in all eight slots.
    task automatic fill_grp();
        set_ctrl(2'b00);
        for (int g = 0; g < 16; g++) wr(AW'(g), {8{4'(g)}});
    endtask

    // Column 5 row y gets y mod 16.
    task automatic fill_mod16();
        set_ctrl(2'b00);
        for (int g = 0; g < 16; g++)
            wr(AW'(g), (g % 2 == 0) ? 32'h76543210 : 32'hFEDCBA98);
    endtask

    task automatic shift_n(int n);
        set_ctrl(2'b01);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        nrst              = 1'b1;
        valid_i           = 1'b1;
        data_i            = 32'hFFFFFFFF;
        input_addr_offset = '0;
        ctrl              = '0;
        tick();
        tick();
        nrst    = 1'b0;
        valid_i = 1'b0;
        chk("reset_out", mk(K_ZERO));
        shift_n(5);
        chk("reset_array_clear", mk(K_ZERO));

        // Write then hold; out-of-range offsets (incl. ones that would wrap) are ignored
        set_ctrl(2'b00);
        wr(32'd3, 32'h76543210);
        chk("write_not_col0", mk(K_ZERO));
        wr(32'd16, 32'hFFFFFFFF);
        wr(32'd19, 32'hFFFFFFFF);
        wr(32'h80000003, 32'hFFFFFFFF);
        set_ctrl(2'b00);
        tick();
        tick();
        chk("hold_col0", mk(K_ZERO));
        shift_n(4);
        chk("off3_shift4", mk(K_ZERO));
        shift_n(1);
        chk("off3_shift5", mk(K_OFF3));
        shift_n(1);
        chk("off3_shift6", mk(K_ZERO));

        // Horizontal pipeline
        fill_grp();
        shift_n(5);
        chk("hpipe_grp", mk(K_GRP));
        shift_n(1);
        chk("hpipe_drain", mk(K_ZERO));

        // Vertical shifts
        fill_mod16();
        shift_n(5);
        chk("vert_base", mk(K_MOD16));
        set_ctrl(2'b10);
        tick();
        chk("vert_up", mk(K_UP));
        fill_mod16();
        shift_n(5);
        chk("vert_base2", mk(K_MOD16));
        set_ctrl(2'b11);
        tick();
        chk("vert_down", mk(K_DOWN));

        // Mid-operation reset discards everything
        fill_mod16();
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        chk("midreset_out", mk(K_ZERO));
        shift_n(5);
        chk("midreset_array", mk(K_ZERO));

        // Write concurrent with shift
        fill_mod16();
        set_ctrl(2'b01);
        wr(32'd0, 32'h11111111);
        shift_n(4);
        chk("wrshift_col4", mk(K_MOD16));
        shift_n(1);
        chk("wrshift_col5", mk(K_ONES8));
        shift_n(1);
        chk("wrshift_drain", mk(K_ZERO));

        // Mixed ctrl: column 0 holds while upper columns advance
        fill_mod16();
        shift_n(5);
        chk("mixed_base", mk(K_MOD16));
        fill_grp();
        ctrl = {{((DX-1)*DY){2'b01}}, {DY{2'b00}}};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mixed_hold", mk(K_MOD16));
        end
        shift_n(1);
        chk("mixed_adv1", mk(K_ZERO));
        shift_n(1);
        chk("mixed_adv2", mk(K_GRP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
